// File: rtl/mem_access_unit_if.sv
// Word-wide data RAM port used by the memory stage.
// The unit (master) raises Mem_Req with stable Mem_We/Mem_Addr/Mem_BE/Mem_WData and keeps them
// that way until the RAM (slave) returns a one-cycle Mem_Ack, with Mem_RData valid in that cycle.
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [3:0]        Mem_BE;
    logic [31:0]       Mem_WData;
    logic              Mem_Ack;
    logic [31:0]       Mem_RData;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
        input  Mem_Ack, Mem_RData
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
        output Mem_Ack, Mem_RData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: performs one lw/lb/sw/sb per Start over the RAM req/ack port,
// holding Busy until the access completes (Done) or is aborted (Err).
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          ADDR_W    = 10,
    parameter int          TIMEOUT   = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     MEM_WrEn,
    input  logic                     ByteOp,
    input  logic [31:0]              ALU_MEM_Addr,
    input  logic [31:0]              MEM_DataIn,
    output logic [31:0]              MEM_DataOut,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Err,
    output logic [1:0]               o_dbg_state,
    mem_access_unit_if.master        mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_lane;
    logic               r_byte;

    logic               w_misaligned;
    logic [ADDR_W-1:0]  w_word_addr;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_timeout;
    logic [7:0]         w_rbyte;
    logic [31:0]        w_load;

    assign o_dbg_state = r_state;

    // Out-of-range addresses simply wrap onto the RAM word index.
    assign w_word_addr  = ADDR_W'((ALU_MEM_Addr - BASE_ADDR) >> 2);
    assign w_misaligned = !ByteOp && (ALU_MEM_Addr[1:0] != 2'b00);
    assign w_be         = ByteOp ? (4'b0001 << ALU_MEM_Addr[1:0]) : 4'b1111;
    assign w_wdata      = ByteOp ? {4{MEM_DataIn[7:0]}} : MEM_DataIn;

    assign w_cnt_next   = r_cnt + 1'b1;
    assign w_timeout    = (w_cnt_next == CNT_W'(TIMEOUT));

    always_comb begin
        w_rbyte = 8'h00;
        case (r_lane)
            2'd0:    w_rbyte = mem.Mem_RData[7:0];
            2'd1:    w_rbyte = mem.Mem_RData[15:8];
            2'd2:    w_rbyte = mem.Mem_RData[23:16];
            default: w_rbyte = mem.Mem_RData[31:24];
        endcase
    end

    assign w_load = r_byte ? {24'h0, w_rbyte} : mem.Mem_RData;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_lane        <= 2'd0;
            r_byte        <= 1'b0;
            MEM_DataOut   <= 32'h0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Err           <= 1'b0;
            mem.Mem_Req   <= 1'b0;
            mem.Mem_We    <= 1'b0;
            mem.Mem_Addr  <= '0;
            mem.Mem_BE    <= 4'h0;
            mem.Mem_WData <= 32'h0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_lane <= ALU_MEM_Addr[1:0];
                        r_byte <= ByteOp;
                        r_cnt  <= '0;
                        Busy   <= 1'b1;
                        if (w_misaligned) begin
                            r_state <= S_FAIL;
                            Err     <= 1'b1;
                        end else begin
                            r_state       <= S_REQ;
                            mem.Mem_Req   <= 1'b1;
                            mem.Mem_We    <= MEM_WrEn;
                            mem.Mem_Addr  <= w_word_addr;
                            mem.Mem_BE    <= w_be;
                            mem.Mem_WData <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_next;
                    // An ack arriving on the final allowed cycle still counts as success.
                    if (mem.Mem_Ack) begin
                        r_state     <= S_RESP;
                        mem.Mem_Req <= 1'b0;
                        mem.Mem_We  <= 1'b0;
                        Done        <= 1'b1;
                        if (!mem.Mem_We) begin
                            MEM_DataOut <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_FAIL;
                        mem.Mem_Req <= 1'b0;
                        mem.Mem_We  <= 1'b0;
                        Err         <= 1'b1;
                    end
                end
                S_RESP, S_FAIL: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
